// File: rtl/sprite_pkg.sv
// Shared types and geometry constants for the sprite scheduler and its
// descriptor table; SCREEN_W/SCREEN_H are also used by sprite_render.
package sprite_pkg;

  localparam int CORDW       = 10;
  localparam int NUM_SPRITES = 16;
  localparam int SPR_WIDTH   = 32;
  localparam int SPR_HEIGHT  = 32;
  localparam int SPR_IDW     = 4;
  localparam int SCREEN_W    = 800;
  localparam int SCREEN_H    = 480;

  localparam int IDX_W   = $clog2(NUM_SPRITES);
  localparam int CNT_W   = IDX_W + 1;
  localparam int SPR_MAX = (SPR_WIDTH > SPR_HEIGHT) ? SPR_WIDTH : SPR_HEIGHT;
  // Wide enough for max coordinate plus an 8x-scaled footprint, so no wrap.
  localparam int FOOT_W  = CORDW + $clog2(8 * SPR_MAX);

  typedef struct packed {
    logic               valid;
    logic [CORDW-1:0]   x;
    logic [CORDW-1:0]   y;
    logic [2:0]         scale;
    logic [SPR_IDW-1:0] id;
  } sprite_desc_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CHECK,
    ARM,
    RUN,
    NEXT,
    DONE
  } sched_state_t;

  function automatic logic fits_on_screen(input logic [CORDW-1:0] pos,
                                          input logic [2:0]       scale,
                                          input int               nominal,
                                          input int               limit);
    logic [FOOT_W-1:0] far_edge;
    far_edge = FOOT_W'(pos) + FOOT_W'(nominal) * (FOOT_W'(scale) + FOOT_W'(1));
    return far_edge <= FOOT_W'(limit);
  endfunction

endpackage

// File: rtl/sprite_desc_table.sv
// Descriptor register file: one write port, one registered read port.
// Reset only invalidates entries; payload fields are left as they were.
module sprite_desc_table
  import sprite_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  sprite_desc_t       wr_desc_i,
  input  logic               rd_en_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output sprite_desc_t       rd_desc_o
);

  sprite_desc_t mem_q [NUM_SPRITES];
  sprite_desc_t rd_desc_q;

  // NOTE: only the valid bits are reset; clearing the whole array would add
  // reset fan-out to every payload flop for data nobody reads while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        mem_q[i].valid <= 1'b0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_desc_i;
    end
  end

  // Read samples the pre-write contents, so a same-edge write is not seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_desc_q <= '0;
    end else if (rd_en_i) begin
      rd_desc_q <= mem_q[rd_idx_i];
    end
  end

  assign rd_desc_o = rd_desc_q;

endmodule

// File: rtl/sprite_scheduler.sv
// Frame sequencer: walks the descriptor table on frame_start and arms
// sprite_render once per valid, fully on-screen entry, in index order.
module sprite_scheduler
  import sprite_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic               wr_valid,
  input  logic [CORDW-1:0]   wr_x,
  input  logic [CORDW-1:0]   wr_y,
  input  logic [2:0]         wr_scale,
  input  logic [SPR_IDW-1:0] wr_id,
  input  logic               frame_start,
  output logic               rnd_rst,
  output logic               rnd_enable,
  output logic [CORDW-1:0]   rnd_sx,
  output logic [CORDW-1:0]   rnd_sy,
  output logic [2:0]         rnd_scale,
  output logic [SPR_IDW-1:0] rnd_id,
  input  logic               rnd_finish,
  output logic               busy,
  output logic               frame_done,
  output logic [CNT_W-1:0]   skip_count,
  output logic               overrun
);

  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] skip_q, skip_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic             rendered_q;
  logic             fetch_en;
  logic             on_screen;
  logic             start_accept;
  sprite_desc_t     wr_desc;
  sprite_desc_t     work;

  assign wr_desc = '{valid: wr_valid, x: wr_x, y: wr_y, scale: wr_scale, id: wr_id};

  sprite_desc_table u_table (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_idx),
    .wr_desc_i (wr_desc),
    .rd_en_i   (fetch_en),
    .rd_idx_i  (idx_q),
    .rd_desc_o (work)
  );

  assign on_screen = fits_on_screen(work.x, work.scale, SPR_WIDTH, SCREEN_W) &&
                     fits_on_screen(work.y, work.scale, SPR_HEIGHT, SCREEN_H);

  assign start_accept = frame_start && (state_q == IDLE);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    skip_d    = skip_q;
    fetch_en  = 1'b0;
    done_d    = (state_q == DONE);
    overrun_d = overrun_q | (frame_start && (state_q != IDLE));
    busy_d    = start_accept ? 1'b1 : (done_q ? 1'b0 : busy_q);

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = FETCH;
          idx_d   = '0;
          skip_d  = '0;
        end
      end
      FETCH: begin
        fetch_en = 1'b1;
        state_d  = CHECK;
      end
      CHECK: begin
        if (!work.valid) begin
          state_d = NEXT;
        end else if (!on_screen) begin
          state_d = NEXT;
          skip_d  = skip_q + CNT_W'(1);
        end else begin
          state_d = ARM;
        end
      end
      ARM:  state_d = RUN;
      RUN: begin
        if (rnd_finish) state_d = NEXT;
      end
      NEXT: begin
        if (idx_q == IDX_W'(NUM_SPRITES - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      skip_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      rendered_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      skip_q     <= skip_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      rendered_q <= (state_q == RUN);
    end
  end

  // The NEXT pulse clears the renderer's held finish after a real render.
  assign rnd_rst    = rst || (state_q == ARM) || ((state_q == NEXT) && rendered_q);
  assign rnd_enable = (state_q == RUN);
  assign rnd_sx     = work.x;
  assign rnd_sy     = work.y;
  assign rnd_scale  = work.scale;
  assign rnd_id     = work.id;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign skip_count = skip_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Randomized bench for sprite_scheduler: a frame-level reference model
// predicts armed sprites, skip count and cycle timing from the table contents.
module tb_sprite_scheduler;

  logic       clk = 1'b0;
  logic       rst, wr_en, wr_valid, frame_start, rnd_finish;
  logic [3:0] wr_idx, wr_id;
  logic [9:0] wr_x, wr_y;
  logic [2:0] wr_scale;
  logic       rnd_rst, rnd_enable, busy, frame_done, overrun;
  logic [9:0] rnd_sx, rnd_sy;
  logic [2:0] rnd_scale;
  logic [3:0] rnd_id;
  logic [4:0] skip_count;

  int n_vec = 0;
  int n_err = 0;

  bit m_valid [16];
  int m_x [16], m_y [16], m_s [16], m_id [16];
  bit m_ovr;

  sprite_scheduler dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_valid(wr_valid),
    .wr_x(wr_x), .wr_y(wr_y), .wr_scale(wr_scale), .wr_id(wr_id),
    .frame_start(frame_start), .rnd_rst(rnd_rst), .rnd_enable(rnd_enable),
    .rnd_sx(rnd_sx), .rnd_sy(rnd_sy), .rnd_scale(rnd_scale), .rnd_id(rnd_id),
    .rnd_finish(rnd_finish), .busy(busy), .frame_done(frame_done),
    .skip_count(skip_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int i, input bit v, input int x, input int y,
                             input int s, input int id);
    wr_en    = 1'b1;
    wr_idx   = 4'(i);
    wr_valid = v;
    wr_x     = 10'(x);
    wr_y     = 10'(y);
    wr_scale = 3'(s);
    wr_id    = 4'(id);
    tick();
    wr_en    = 1'b0;
    m_valid[i] = v;
    m_x[i] = x; m_y[i] = y; m_s[i] = s; m_id[i] = id;
  endtask

  function automatic bit visible(input int i);
    int side;
    side = 32 * (m_s[i] + 1);
    return m_valid[i] && (m_x[i] + side <= 800) && (m_y[i] + side <= 480);
  endfunction

  // Plays the renderer (finish after lat enabled cycles) for one frame.
  // A second frame_start is injected after edge 'inject' when inject > 0.
  task automatic run_frame(input int lat, input int inject);
    int exp_idx[$];
    int exp_arm[$];
    int acc, exp_skip, exp_done;
    int e, k, cnt, run_len, bad_busy, dones, done_e, i;
    bit prev_en, prev_rst;
    acc = 0; exp_skip = 0;
    for (int j = 0; j < 16; j++) begin
      if (visible(j)) begin
        exp_idx.push_back(j);
        exp_arm.push_back(acc + 3);
        acc += lat + 4;
      end else begin
        if (m_valid[j]) exp_skip++;
        acc += 3;
      end
    end
    exp_done = acc + 2;
    if (inject > 0) m_ovr = 1'b1;

    k = 0; cnt = 0; run_len = 0; bad_busy = 0; dones = 0; done_e = -1;
    prev_en = 1'b0; prev_rst = 1'b0;
    frame_start = 1'b1;
    for (e = 1; e <= 20000; e++) begin
      tick();
      frame_start = 1'b0;
      if (rnd_enable && !prev_en) begin
        if (k < exp_idx.size()) begin
          i = exp_idx[k];
          check("arm_edge", e, exp_arm[k] + 1);
          check("arm_rst", prev_rst, 1);
          check("arm_sx", rnd_sx, m_x[i]);
          check("arm_sy", rnd_sy, m_y[i]);
          check("arm_scale", rnd_scale, m_s[i]);
          check("arm_id", rnd_id, m_id[i]);
        end else begin
          check("extra_arm", k, exp_idx.size());
        end
        k++;
        run_len = 0;
      end
      if (rnd_enable) run_len++;
      if (!rnd_enable && prev_en) check("run_len", run_len, lat);
      if (rnd_rst) begin
        rnd_finish = 1'b0;
        cnt = 0;
      end else if (rnd_enable) begin
        cnt++;
        if (cnt >= lat) rnd_finish = 1'b1;
      end
      prev_en  = rnd_enable;
      prev_rst = rnd_rst;
      if (busy !== 1'b1) bad_busy++;
      if (e == inject) frame_start = 1'b1;
      if (frame_done) begin
        dones++;
        done_e = e;
        break;
      end
    end
    if (dones == 0) check("frame_done_timeout", 0, 1);
    check("done_edge", done_e, exp_done);
    check("arm_count", k, exp_idx.size());
    check("skip_count", skip_count, exp_skip);
    check("busy_window", bad_busy, 0);
    check("overrun", overrun, m_ovr);
    tick();
    check("busy_after", busy, 0);
    check("done_once", frame_done, 0);
  endtask

  initial begin
    int s, w, x, y;
    rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_valid = 1'b0; wr_x = '0; wr_y = '0;
    wr_scale = '0; wr_id = '0; frame_start = 1'b0; rnd_finish = 1'b0; m_ovr = 1'b0;
    for (int j = 0; j < 16; j++) begin
      m_valid[j] = 1'b0; m_x[j] = 0; m_y[j] = 0; m_s[j] = 0; m_id[j] = 0;
    end
    tick(); tick();
    check("rst_rnd_rst", rnd_rst, 1);
    check("rst_enable", rnd_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_skip", skip_count, 0);
    check("rst_overrun", overrun, 0);
    check("rst_sx", rnd_sx, 0);
    rst = 1'b0;
    tick();
    check("idle_rnd_rst", rnd_rst, 0);

    run_frame(4, 0);

    write_entry(0, 1, 100, 50, 0, 3);
    run_frame(1024, 0);

    write_entry(0, 1, 780, 0, 0, 1);
    write_entry(1, 1, 768, 0, 0, 2);
    run_frame(5, 0);

    write_entry(2, 1, 0, 0, 3, 5);
    write_entry(3, 1, 0, 400, 3, 6);
    run_frame(3, 0);

    check("overrun_before", overrun, 0);
    run_frame(20, 7);

    for (int f = 0; f < 8; f++) begin
      for (int j = 0; j < 16; j++) begin
        s = $urandom_range(0, 7);
        w = 32 * (s + 1);
        x = ($urandom_range(0, 3) == 0) ? 800 - w - 1 + $urandom_range(0, 2) : $urandom_range(0, 1023);
        y = ($urandom_range(0, 3) == 0) ? 480 - w - 1 + $urandom_range(0, 2) : $urandom_range(0, 1023);
        write_entry(j, $urandom_range(0, 1), x, y, s, $urandom_range(0, 15));
      end
      run_frame($urandom_range(1, 8), 0);
    end

    write_entry(0, 1, 10, 10, 0, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (4) tick();
    check("pre_rst_enable", rnd_enable, 1);
    rst = 1'b1;
    #1;
    check("rst_forward", rnd_rst, 1);
    tick();
    check("midrun_enable", rnd_enable, 0);
    check("midrun_busy", busy, 0);
    check("midrun_overrun", overrun, 0);
    check("midrun_done", frame_done, 0);
    check("midrun_sx", rnd_sx, 0);
    rst = 1'b0;
    rnd_finish = 1'b0;
    m_ovr = 1'b0;
    for (int j = 0; j < 16; j++) m_valid[j] = 1'b0;
    tick();
    run_frame(3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
